twiddle_pingpong_ram: RTL and testbench

// Double-buffered (ping-pong) twiddle-factor store for the NTT datapath. The butterfly array

---
 rtl/twiddle_pingpong_ram.sv | 142 ++++++++++++++
 tb/tb_twiddle_pingpong_ram.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_pingpong_ram
// Brief    : Ping-pong twiddle store; registered multi-port reads of the active
//            page, streamed loading of the shadow page, swap on command.
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_pingpong_ram #(
  parameter int W      = 32,
  parameter int DEPTH  = 8,
  parameter int NUM_RD = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [W-1:0]         ld_data,
  output logic                 ld_done,
  input  logic                 swap,
  output logic                 swap_err,
  output logic                 active_full,
  input  logic [NUM_RD-1:0]    rd_en,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*W-1:0]  rd_data,
  output logic [NUM_RD-1:0]    rd_valid
);

  localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);
  localparam logic [AW:0]   c_depth = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_LOADED = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic            r_active_page;
  logic            r_active_full;
  logic            r_ld_ready;
  logic            r_ld_done;
  logic            r_swap_err;
  logic [W-1:0]    r_mem [2][DEPTH];
  logic            w_wr_en;

  assign ld_ready    = r_ld_ready;
  assign ld_done     = r_ld_done;
  assign swap_err    = r_swap_err;
  assign active_full = r_active_full;
  assign w_wr_en     = rst_n && (r_state == S_LOAD) && ld_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_active_page <= 1'b0;
      r_active_full <= 1'b0;
      r_ld_ready    <= 1'b0;
      r_ld_done     <= 1'b0;
      r_swap_err    <= 1'b0;
    end else begin
      r_ld_done  <= 1'b0;
      r_swap_err <= swap && (r_state != S_LOADED);
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state    <= S_LOAD;
            r_wr_ptr   <= '0;
            r_ld_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            if (r_wr_ptr == c_last) begin
              r_state    <= S_LOADED;
              r_wr_ptr   <= '0;
              r_ld_ready <= 1'b0;
              r_ld_done  <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
            end
          end
        end
        S_LOADED: begin
          if (swap) begin
            r_active_page <= ~r_active_page;
            r_active_full <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Page storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[~r_active_page][r_wr_ptr] <= ld_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_in_range;
      logic [W-1:0]  r_data;
      logic          r_valid;

      if (DEPTH == 1) begin : g_single
        logic w_unused_addr;
        assign w_unused_addr = ^rd_addr[gi*AW +: AW];
        assign w_addr        = '0;
        assign w_in_range    = 1'b1;
      end else begin : g_multi
        assign w_addr     = rd_addr[gi*AW +: AW];
        assign w_in_range = ({1'b0, w_addr} < c_depth);
      end

      // Reads sample the page selected before any swap at this same edge.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (rd_en[gi]) begin
          r_data  <= w_in_range ? r_mem[r_active_page][w_addr] : '0;
          r_valid <= r_active_full;
        end else begin
          r_valid <= 1'b0;
        end
      end

      assign rd_data[gi*W +: W] = r_data;
      assign rd_valid[gi]       = r_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_twiddle_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_twiddle_pingpong_ram
// Brief    : Directed/randomized bench for twiddle_pingpong_ram with a set-level
//            reference model (expected active and shadow twiddle sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_twiddle_pingpong_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Main instance: W=32, DEPTH=8, NUM_RD=2
  logic        a_load_start, a_ld_valid, a_ld_ready, a_ld_done;
  logic        a_swap, a_swap_err, a_active_full;
  logic [31:0] a_ld_data;
  logic [1:0]  a_rd_en, a_rd_valid;
  logic [5:0]  a_rd_addr;
  logic [63:0] a_rd_data;

  // DEPTH=1, NUM_RD=1
  logic        b_load_start, b_ld_valid, b_ld_ready, b_ld_done;
  logic        b_swap, b_swap_err, b_active_full;
  logic [31:0] b_ld_data;
  logic [0:0]  b_rd_en, b_rd_valid, b_rd_addr;
  logic [31:0] b_rd_data;

  // DEPTH=5, NUM_RD=4
  logic         c_load_start, c_ld_valid, c_ld_ready, c_ld_done;
  logic         c_swap, c_swap_err, c_active_full;
  logic [31:0]  c_ld_data;
  logic [3:0]   c_rd_en, c_rd_valid;
  logic [11:0]  c_rd_addr;
  logic [127:0] c_rd_data;

  twiddle_pingpong_ram #(.W(32), .DEPTH(8), .NUM_RD(2)) u_a (
    .clk(clk), .rst_n(rst_n), .load_start(a_load_start), .ld_valid(a_ld_valid),
    .ld_ready(a_ld_ready), .ld_data(a_ld_data), .ld_done(a_ld_done), .swap(a_swap),
    .swap_err(a_swap_err), .active_full(a_active_full), .rd_en(a_rd_en),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid));

  twiddle_pingpong_ram #(.W(32), .DEPTH(1), .NUM_RD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .load_start(b_load_start), .ld_valid(b_ld_valid),
    .ld_ready(b_ld_ready), .ld_data(b_ld_data), .ld_done(b_ld_done), .swap(b_swap),
    .swap_err(b_swap_err), .active_full(b_active_full), .rd_en(b_rd_en),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid));

  twiddle_pingpong_ram #(.W(32), .DEPTH(5), .NUM_RD(4)) u_c (
    .clk(clk), .rst_n(rst_n), .load_start(c_load_start), .ld_valid(c_ld_valid),
    .ld_ready(c_ld_ready), .ld_data(c_ld_data), .ld_done(c_ld_done), .swap(c_swap),
    .swap_err(c_swap_err), .active_full(c_active_full), .rd_en(c_rd_en),
    .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid));

  int checks = 0;
  int errors = 0;

  // Reference model: the twiddle set readable now, and the set being staged.
  logic [31:0] exp_act [8];
  logic [31:0] exp_sh  [8];
  logic        exp_full;
  logic [31:0] c_exp   [5];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    a_load_start = 1'($urandom); a_ld_valid = 1'($urandom); a_ld_data = $urandom;
    a_swap = 1'($urandom); a_rd_en = 2'($urandom); a_rd_addr = 6'($urandom);
    b_load_start = 1'($urandom); b_ld_valid = 1'($urandom); b_ld_data = $urandom;
    b_swap = 1'($urandom); b_rd_en = 1'($urandom); b_rd_addr = 1'($urandom);
    c_load_start = 1'($urandom); c_ld_valid = 1'($urandom); c_ld_data = $urandom;
    c_swap = 1'($urandom); c_rd_en = 4'($urandom); c_rd_addr = 12'($urandom);
  endtask

  task automatic clear_inputs();
    a_load_start = 0; a_ld_valid = 0; a_ld_data = 0; a_swap = 0; a_rd_en = 0; a_rd_addr = 0;
    b_load_start = 0; b_ld_valid = 0; b_ld_data = 0; b_swap = 0; b_rd_en = 0; b_rd_addr = 0;
    c_load_start = 0; c_ld_valid = 0; c_ld_data = 0; c_swap = 0; c_rd_en = 0; c_rd_addr = 0;
  endtask

  task automatic start_load();
    a_load_start = 1'b1;
    step();
    a_load_start = 1'b0;
    chk("ld_ready_after_start", a_ld_ready, 1);
  endtask

  // Stream n beats (base+first .. base+first+n-1) with random idle gaps while
  // port 0 reads random addresses of the active set.
  task automatic send_beats(input logic [31:0] base, input int first, input int n,
                            input bit expect_done);
    int          gap;
    logic [2:0]  ra;
    bit          last;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        a_ld_valid = (g == gap);
        a_ld_data  = (g == gap) ? base + 32'(first + k) : $urandom;
        ra         = 3'($urandom_range(0, 7));
        a_rd_en    = 2'b01;
        a_rd_addr  = {3'd0, ra};
        last       = (g == gap) && (k == n - 1) && expect_done;
        chk("ld_ready_in_load", a_ld_ready, 1);
        step();
        chk("rd0_valid_during_load", a_rd_valid[0], exp_full);
        chk("rd1_idle_during_load", a_rd_valid[1], 0);
        if (exp_full) chk("rd0_data_during_load", a_rd_data[31:0], exp_act[ra]);
        chk("ld_done_timing", a_ld_done, last);
      end
      exp_sh[first + k] = base + 32'(first + k);
    end
    a_ld_valid = 1'b0;
    a_rd_en    = 2'b00;
    if (expect_done) begin
      chk("ld_ready_after_load", a_ld_ready, 0);
      step();
      chk("ld_done_single_pulse", a_ld_done, 0);
    end
  endtask

  task automatic do_swap();
    a_swap = 1'b1;
    step();
    a_swap = 1'b0;
    exp_act  = exp_sh;
    exp_full = 1'b1;
    chk("active_full_after_swap", a_active_full, 1);
    chk("no_swap_err_in_loaded", a_swap_err, 0);
  endtask

  task automatic read_pair(input logic [2:0] ad0, input logic [2:0] ad1, input string tag);
    a_rd_en   = 2'b11;
    a_rd_addr = {ad1, ad0};
    step();
    a_rd_en = 2'b00;
    chk({tag, "_p0"}, a_rd_data[31:0], exp_act[ad0]);
    chk({tag, "_p1"}, a_rd_data[63:32], exp_act[ad1]);
    chk({tag, "_valid"}, a_rd_valid, {exp_full, exp_full});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_act[i] = 'x;
      exp_sh[i]  = 'x;
    end

    // Reset with random inputs
    rst_n = 1'b0;
    rand_inputs();
    step();
    rand_inputs();
    step();
    chk("rst_ld_ready", a_ld_ready, 0);
    chk("rst_ld_done", a_ld_done, 0);
    chk("rst_swap_err", a_swap_err, 0);
    chk("rst_active_full", a_active_full, 0);
    chk("rst_rd_valid", a_rd_valid, 0);
    chk("rst_rd_data", a_rd_data, 0);
    chk("rst_c_rd_data", c_rd_data, 0);
    chk("rst_b_outputs", {b_ld_ready, b_ld_done, b_swap_err, b_active_full, b_rd_valid}, 0);
    clear_inputs();
    rst_n     = 1'b1;
    a_rd_en   = 2'b11;
    a_rd_addr = 6'($urandom);
    step();
    a_rd_en = 2'b00;
    chk("rd_valid_empty_page", a_rd_valid, 0);

    // Load 0x100.. and swap
    start_load();
    send_beats(32'h100, 0, 8, 1);
    do_swap();
    read_pair(3'd3, 3'd7, "read_3_7");
    chk("read_3_abs", a_rd_data[31:0], 32'h103);
    chk("read_7_abs", a_rd_data[63:32], 32'h107);

    // Concurrent load of 0x200.. while reading the active set
    start_load();
    send_beats(32'h200, 0, 8, 1);
    a_swap    = 1'b1;
    a_rd_en   = 2'b01;
    a_rd_addr = 6'd5;
    step();
    a_swap = 1'b0;
    chk("read_in_swap_cycle_old", a_rd_data[31:0], exp_act[5]);
    exp_act  = exp_sh;
    exp_full = 1'b1;
    step();
    a_rd_en = 2'b00;
    chk("read_after_swap_new", a_rd_data[31:0], exp_act[5]);
    chk("read_after_swap_abs", a_rd_data[31:0], 32'h205);
    chk("read_after_swap_valid", a_rd_valid[0], 1);

    // Protocol errors: swap in IDLE
    a_swap = 1'b1;
    step();
    a_swap = 1'b0;
    chk("swap_err_idle", a_swap_err, 1);
    step();
    chk("swap_err_idle_pulse", a_swap_err, 0);
    read_pair(3'd1, 3'd6, "page_kept_idle");

    // swap during LOAD, then load_start during LOAD
    start_load();
    a_swap = 1'b1;
    step();
    a_swap = 1'b0;
    chk("swap_err_load", a_swap_err, 1);
    chk("still_loading", a_ld_ready, 1);
    read_pair(3'd2, 3'd4, "page_kept_load");
    chk("swap_err_load_pulse", a_swap_err, 0);
    send_beats(32'h300, 0, 3, 0);
    a_load_start = 1'b1;
    step();
    a_load_start = 1'b0;
    chk("restart_ignored_ready", a_ld_ready, 1);
    send_beats(32'h300, 3, 5, 1);
    do_swap();
    for (int i = 0; i < 8; i++) read_pair(3'(i), 3'(7 - i), "ptr_kept");

    // Reset mid-load, then a fresh load
    start_load();
    send_beats(32'h400, 0, 4, 0);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    exp_full = 1'b0;
    chk("midrst_ld_ready", a_ld_ready, 0);
    chk("midrst_active_full", a_active_full, 0);
    a_ld_valid = 1'b1;
    a_ld_data  = 32'hDEAD;
    a_rd_en    = 2'b11;
    step();
    a_ld_valid = 1'b0;
    a_rd_en    = 2'b00;
    chk("no_load_without_start", a_ld_ready, 0);
    chk("no_done_without_start", a_ld_done, 0);
    chk("midrst_rd_valid", a_rd_valid, 0);
    start_load();
    send_beats(32'h500, 0, 8, 1);
    do_swap();
    read_pair(3'd2, 3'd6, "after_midrst");

    // DEPTH=1
    b_load_start = 1'b1;
    step();
    b_load_start = 1'b0;
    chk("d1_ld_ready", b_ld_ready, 1);
    b_ld_valid = 1'b1;
    b_ld_data  = 32'hABC;
    step();
    b_ld_valid = 1'b0;
    chk("d1_ld_done", b_ld_done, 1);
    chk("d1_ld_ready_off", b_ld_ready, 0);
    b_swap = 1'b1;
    step();
    b_swap = 1'b0;
    chk("d1_active_full", b_active_full, 1);
    b_rd_en   = 1'b1;
    b_rd_addr = 1'($urandom);
    step();
    b_rd_en = 1'b0;
    chk("d1_rd_data", b_rd_data, 32'hABC);
    chk("d1_rd_valid", b_rd_valid, 1);

    // DEPTH=5, NUM_RD=4
    c_load_start = 1'b1;
    step();
    c_load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c_exp[i]   = 32'h600 + 32'(i);
      c_ld_valid = 1'b1;
      c_ld_data  = c_exp[i];
      step();
    end
    c_ld_valid = 1'b0;
    chk("d5_ld_done", c_ld_done, 1);
    c_swap = 1'b1;
    step();
    c_swap = 1'b0;
    chk("d5_active_full", c_active_full, 1);
    c_rd_en   = 4'hF;
    c_rd_addr = {3'd2, 3'd2, 3'd2, 3'd2};
    step();
    for (int p = 0; p < 4; p++) chk("r4_same_addr", c_rd_data[p*32 +: 32], c_exp[2]);
    chk("r4_valid", c_rd_valid, 4'hF);
    c_rd_addr = {3'd4, 3'd7, 3'd5, 3'd6};
    step();
    c_rd_en = 4'h0;
    chk("d5_oor_6", c_rd_data[31:0], 0);
    chk("d5_oor_5", c_rd_data[63:32], 0);
    chk("d5_oor_7", c_rd_data[95:64], 0);
    chk("d5_last_4", c_rd_data[127:96], c_exp[4]);
    chk("d5_oor_valid", c_rd_valid, 4'hF);
    step();
    chk("d5_valid_drop", c_rd_valid, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
